// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          INST_W         = 16;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ir_reg.sv
// Instruction/PC holding register; captures a new word only on load.
module ir_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] d_inst,
  input  logic [15:0]       d_pc,
  output logic [INST_W-1:0] inst,
  output logic [15:0]       inst_pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (load) begin
      inst    <= d_inst;
      inst_pc <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Three-state fetch sequencer in front of a 1-cycle synchronous BRAM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = FETCH_RESET_PC,
  parameter int          MEM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [15:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [15:0]       redirect_pc,
  output fetch_state_e      dbg_state
);

  // Handshake: an instruction transfers on a rising edge where inst_valid and
  // inst_ready are both 1; inst/inst_pc stay stable while valid and not ready.

  fetch_state_e state;
  logic [15:0]  pc;
  logic         ir_load;

  assign mem_addr   = pc[MEM_AW-1:0];
  assign inst_valid = (state == S_HOLD);
  assign dbg_state  = state;

  // A redirect in S_WAIT must not capture the stale word for the old pc.
  assign ir_load = (state == S_WAIT) && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      state <= S_ISSUE;
    end else if (redirect) begin
      pc    <= redirect_pc;
      state <= S_ISSUE;
    end else begin
      case (state)
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_HOLD;
        S_HOLD: begin
          if (inst_ready) begin
            pc    <= pc + 16'd1;
            state <= S_ISSUE;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

  ir_reg u_ir_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ir_load),
    .d_inst  (mem_rdata),
    .d_pc    (pc),
    .inst    (inst),
    .inst_pc (inst_pc)
  );

endmodule
